mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips_pkg.sv | 15 +
 rtl/sat_counter.sv | 31 +++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the memory port arbiter: parameter defaults and arbiter state encoding.
package mips_pkg;

  localparam int ADDR_W_DEF        = 32;
  localparam int DATA_W_DEF        = 32;
  localparam int MAX_DM_STREAK_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that increments while inc_i is high and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single shared memory port between instruction fetch (IF) and data (DM) requesters,
// bounding consecutive DM grants while a fetch is waiting.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_DM_STREAK = MAX_DM_STREAK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic [15:0]       stall_cnt_o
);

  localparam int STREAK_W = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  arb_state_e          state_q, state_d;
  logic                win_dm_q, win_dm_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                grant_dm;
  logic                grant_if;
  logic                busy;

  always_comb begin
    state_d    = state_q;
    win_dm_d   = win_dm_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (dm_req_i && ((streak_q < STREAK_MAX) || !if_req_i)) begin
            grant_dm = 1'b1;
          end else if (if_req_i) begin
            grant_if = 1'b1;
          end
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ack_i) begin
          // Writes return no data, so the read-data registers keep their last value.
          if (!we_q) begin
            if (win_dm_q) begin
              dm_rdata_d = mem_rdata_i;
            end else begin
              if_rdata_d = mem_rdata_i;
            end
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_dm) begin
      state_d  = DM_BUSY;
      win_dm_d = 1'b1;
      addr_d   = dm_addr_i;
      we_d     = dm_we_i;
      wdata_d  = dm_wdata_i;
      if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 1'b1;
      end
    end

    if (grant_if) begin
      state_d  = IF_BUSY;
      win_dm_d = 1'b0;
      addr_d   = if_addr_i;
      we_d     = 1'b0;
      wdata_d  = '0;
      streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_dm_q   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      win_dm_q   <= win_dm_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign busy        = (state_q == IF_BUSY) || (state_q == DM_BUSY);
  assign mem_req_o   = busy;
  assign mem_we_o    = busy & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign if_ack_o    = (state_q == RESP) & ~win_dm_q;
  assign dm_ack_o    = (state_q == RESP) &  win_dm_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

  assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  sat_counter #(
    .WIDTH (16)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_o),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences, random run vs. model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ack_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;
  logic          stall_o;
  logic [15:0]   stall_cnt_o;

  mem_port_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .MAX_DM_STREAK (MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ack_o    (dm_ack_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .stall_o     (stall_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One row per clock cycle: inputs applied at the falling edge, outputs compared 1 time unit later.
  typedef struct {
    logic          start, ifr, dmr, we, mack;
    logic [DW-1:0] rdata;
    logic          e_mreq, e_mwe, e_ifack, e_dmack, e_stall;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ifr, logic dmr, logic we, logic mack, logic [DW-1:0] rdata,
                              logic e_mreq, logic e_mwe, logic e_ifack, logic e_dmack, logic e_stall,
                              logic [AW-1:0] e_addr);
    vec_t v;
    v.start = 1'b1; v.ifr = ifr; v.dmr = dmr; v.we = we; v.mack = mack; v.rdata = rdata;
    v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_ifack = e_ifack; v.e_dmack = e_dmack;
    v.e_stall = e_stall; v.e_addr = e_addr;
    return v;
  endfunction

  // Random-run reference: transaction-level view of the port plus a grant history for the streak rule.
  int            phase;
  bit            who_dm;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            m_we;
  logic [DW-1:0] m_ifrd, m_dmrd;
  int unsigned   m_cnt;
  int            hist[$];

  function automatic int trailing_dm();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != 1) break;
      n++;
    end
    return n;
  endfunction

  initial begin
    logic [AW-1:0] grants[$];
    logic [AW-1:0] exp_order[6];
    int            seen_req;
    int            seen_ack;
    bit            if_pend, dm_pend;
    bit            e_ifack, e_dmack, e_stall;

    rst = 1'b1;
    idle_inputs();
    do_reset();

    @(negedge clk); #1;
    chk("reset mem_req", mem_req_o, 1'b0);
    chk("reset if_ack", if_ack_o, 1'b0);
    chk("reset dm_ack", dm_ack_o, 1'b0);
    chk("reset stall_cnt", stall_cnt_o, 16'd0);
    chk("reset if_rdata", if_rdata_o, 32'd0);
    chk("reset dm_rdata", dm_rdata_o, 32'd0);

    // DM read, DM write with 3 wait cycles, then a single fetch with ignored acks in IDLE/RESP.
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h04));
    vecs.push_back(mk(0, 1, 0, 1, 32'h12345678, 1, 0, 0, 0, 1, 32'h04));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h04));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h04));
    vecs.push_back(mk(0, 1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h04));
    vecs.push_back(mk(0, 1, 1, 0, 32'hDEADBEEF, 1, 1, 0, 0, 1, 32'h04));
    vecs.push_back(mk(0, 1, 1, 0, 32'hDEADBEEF, 1, 1, 0, 0, 1, 32'h04));
    vecs.push_back(mk(0, 1, 1, 0, 32'hDEADBEEF, 1, 1, 0, 0, 1, 32'h04));
    vecs.push_back(mk(0, 1, 1, 1, 32'hDEADBEEF, 1, 1, 0, 0, 1, 32'h04));
    vecs.push_back(mk(0, 1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0, 32'h04));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h04));
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,        0, 0, 0, 0, 1, 32'h10));
    vecs.push_back(mk(1, 0, 0, 1, 32'h8C080000, 1, 0, 0, 0, 1, 32'h10));
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,        0, 0, 1, 0, 0, 32'h10));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h10));

    if_addr_i = 32'h10; dm_addr_i = 32'h04; dm_wdata_i = 32'd5;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start = vecs[i].start; if_req_i = vecs[i].ifr; dm_req_i = vecs[i].dmr;
      dm_we_i = vecs[i].we; mem_ack_i = vecs[i].mack; mem_rdata_i = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d mem_req", i), mem_req_o, vecs[i].e_mreq);
      chk($sformatf("vec%0d mem_we", i), mem_we_o, vecs[i].e_mwe);
      chk($sformatf("vec%0d if_ack", i), if_ack_o, vecs[i].e_ifack);
      chk($sformatf("vec%0d dm_ack", i), dm_ack_o, vecs[i].e_dmack);
      chk($sformatf("vec%0d stall", i), stall_o, vecs[i].e_stall);
      if (vecs[i].e_mreq) begin
        chk($sformatf("vec%0d mem_addr", i), mem_addr_o, vecs[i].e_addr);
        if (vecs[i].e_mwe) chk($sformatf("vec%0d mem_wdata", i), mem_wdata_o, 32'd5);
      end
    end
    chk("dm_rdata kept after write", dm_rdata_o, 32'h12345678);
    chk("if_rdata fetched", if_rdata_o, 32'h8C080000);

    // Both requesters held continuously with a zero-wait memory.
    exp_order = '{32'h200, 32'h200, 32'h100, 32'h200, 32'h200, 32'h100};
    do_reset();
    @(negedge clk);
    start = 1'b1; if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'b0;
    if_addr_i = 32'h100; dm_addr_i = 32'h200; mem_ack_i = 1'b1;
    for (int c = 0; c < 40 && grants.size() < 6; c++) begin
      #1;
      if (mem_req_o) grants.push_back(mem_addr_o);
      @(negedge clk);
    end
    if_req_i = 1'b0; dm_req_i = 1'b0; mem_ack_i = 1'b0;
    chk("grant order count", grants.size(), 6);
    for (int g = 0; g < 6; g++) begin
      if (g < grants.size()) chk($sformatf("grant order %0d", g), grants[g], exp_order[g]);
    end

    // Reset in the second DM_BUSY cycle, then a stray memory ack.
    do_reset();
    @(negedge clk);
    start = 1'b1; dm_req_i = 1'b1; dm_addr_i = 32'h40;
    @(negedge clk); #1;
    chk("pre-reset busy1", mem_req_o, 1'b1);
    @(negedge clk); #1;
    chk("pre-reset busy2", mem_req_o, 1'b1);
    rst = 1'b1; dm_req_i = 1'b0; start = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE0001;
    #1;
    chk("rst abandon mem_req", mem_req_o, 1'b0);
    chk("rst abandon dm_ack", dm_ack_o, 1'b0);
    chk("rst stall_cnt", stall_cnt_o, 16'd0);
    chk("rst dm_rdata", dm_rdata_o, 32'd0);
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    chk("late ack dm_ack", dm_ack_o, 1'b0);
    chk("late ack if_ack", if_ack_o, 1'b0);
    chk("late ack mem_req", mem_req_o, 1'b0);
    chk("late ack dm_rdata", dm_rdata_o, 32'd0);

    // start dropped while a fetch is in flight.
    do_reset();
    @(negedge clk);
    start = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h80;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start drop busy", mem_req_o, 1'b1);
    @(negedge clk);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    chk("start drop if_ack", if_ack_o, 1'b1);
    chk("start drop if_rdata", if_rdata_o, 32'h0BADF00D);
    @(negedge clk);
    if_req_i = 1'b0; dm_req_i = 1'b1; dm_addr_i = 32'h44;
    seen_req = 0; seen_ack = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_req_o) seen_req++;
      if (dm_ack_o) seen_ack++;
      @(negedge clk);
    end
    chk("no grant without start", seen_req, 0);
    chk("no dm_ack without start", seen_ack, 0);

    // Fetch that memory never answers: stall counter must stick at all-ones.
    do_reset();
    @(negedge clk);
    start = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h1000;
    repeat (100) @(negedge clk);
    #1;
    chk("stall_cnt 100", stall_cnt_o, 16'd100);
    repeat (69900) @(negedge clk);
    #1;
    chk("stall_cnt saturated", stall_cnt_o, 16'hFFFF);
    chk("stall held", stall_o, 1'b1);

    // Random traffic against the reference model.
    do_reset();
    phase = 0; who_dm = 0; m_addr = '0; m_wdata = '0; m_we = 0;
    m_ifrd = '0; m_dmrd = '0; m_cnt = 0; hist.delete();
    if_pend = 0; dm_pend = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr_i = $urandom;
      end
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend = 1; dm_addr_i = $urandom; dm_we_i = 1'($urandom_range(0, 1)); dm_wdata_i = $urandom;
      end
      if (phase == 1) begin
        if (who_dm) dm_addr_i = $urandom;
        else        if_addr_i = $urandom;
      end
      if_req_i = if_pend; dm_req_i = dm_pend;
      start = ($urandom_range(0, 7) != 0);
      mem_ack_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i = $urandom;
      #1;
      e_ifack = (phase == 2) && !who_dm;
      e_dmack = (phase == 2) && who_dm;
      e_stall = (if_pend && !e_ifack) || (dm_pend && !e_dmack);
      chk("rnd mem_req", mem_req_o, (phase == 1));
      chk("rnd if_ack", if_ack_o, e_ifack);
      chk("rnd dm_ack", dm_ack_o, e_dmack);
      chk("rnd stall", stall_o, e_stall);
      chk("rnd stall_cnt", stall_cnt_o, m_cnt[15:0]);
      chk("rnd if_rdata", if_rdata_o, m_ifrd);
      chk("rnd dm_rdata", dm_rdata_o, m_dmrd);
      if (phase == 1) begin
        chk("rnd mem_addr", mem_addr_o, m_addr);
        chk("rnd mem_we", mem_we_o, m_we);
        if (m_we) chk("rnd mem_wdata", mem_wdata_o, m_wdata);
      end
      if (e_stall && m_cnt < 65535) m_cnt++;
      case (phase)
        0: begin
          if (start) begin
            if (dm_pend && (trailing_dm() < MAX || !if_pend)) begin
              who_dm = 1; m_addr = dm_addr_i; m_we = dm_we_i; m_wdata = dm_wdata_i;
              hist.push_back(1); phase = 1;
            end else if (if_pend) begin
              who_dm = 0; m_addr = if_addr_i; m_we = 0;
              hist.push_back(0); phase = 1;
            end
          end
        end
        1: begin
          if (mem_ack_i) begin
            if (!m_we) begin
              if (who_dm) m_dmrd = mem_rdata_i;
              else        m_ifrd = mem_rdata_i;
            end
            phase = 2;
          end
        end
        default: phase = 0;
      endcase
      if (e_ifack) if_pend = 0;
      if (e_dmack) dm_pend = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
